seg7_io_ctrl: RTL and testbench

- Downstream consumer of the memory/IO mux's seven-segment chip-select and 32-bit write data.
- Latches the word written by the CPU's IO-write (a7 = 5) and drives the board's 8-digit, two-bus seven-segment display.
- Time-multiplexes 4 phases; each phase lights one left-group digit and one right-group digit at once.
- Hex display in the base build; optional sequential binary-to-decimal mode.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_bin2bcd.sv | 80 ++++++++
 rtl/seg7_io_ctrl.sv | 102 ++++++++++
 tb/tb_seg7_io_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and the segment encoder for the seven-segment display controller.
//   PHASE_W / DIGITS : scan phase counter width and digit count
//   DATA_W / BCD_W   : written word width and double-dabble result width
//   seg_enc()        : nibble -> {dp,g,f,e,d,c,b,a}, dp always 0
package seg7_pkg;

  localparam int unsigned PHASE_W = 2;
  localparam int unsigned DIGITS  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BCD_W   = 40;

  // Active-high segment patterns for hex digits 0..F.
  function automatic logic [7:0] seg_enc(input logic [3:0] nib);
    logic [7:0] seg;
    seg = 8'h00;
    case (nib)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      4'hF: seg = 8'h71;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble converter: one shift-and-add-3 iteration per clock.
//   clk, rst_n : clock, async active-low reset
//   start      : load bin and (re)start; aborts a conversion in progress
//   bin        : 32-bit binary input, sampled with start
//   busy       : registered, high from the cycle after start until completion
//   done_c     : combinational, high in the completion cycle (bcd valid)
//   bcd        : 40-bit result (10 BCD digits)
module seg7_bin2bcd
  import seg7_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done_c,
  output logic [BCD_W-1:0]  bcd
);

  localparam int unsigned ITER_W = 5;
  localparam int unsigned NDIG   = BCD_W / 4;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  sh_bin;
  logic [ITER_W-1:0]  iter;
  logic [BCD_W-1:0]   bcd_adj_c;

  // Add 3 to every BCD digit that is 5 or more before the shift.
  always_comb begin
    bcd_adj_c = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state; start overrides everything so a new word restarts the count.
  always_comb begin
    state_nxt = state;
    done_c    = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = ST_IDLE;
      ST_SHIFT: if (iter == ITER_W'(DATA_W - 1)) state_nxt = ST_DONE;
      ST_DONE: begin
        state_nxt = ST_IDLE;
        done_c    = !start;
      end
      default:  state_nxt = ST_IDLE;
    endcase
    if (start) state_nxt = ST_SHIFT;
  end

  // Datapath: iterations run on the 32 edges after start, busy drops in ST_DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      iter   <= '0;
      sh_bin <= '0;
      bcd    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      iter   <= '0;
      sh_bin <= bin;
      bcd    <= '0;
    end else if (state == ST_SHIFT) begin
      bcd    <= {bcd_adj_c[BCD_W-2:0], sh_bin[DATA_W-1]};
      sh_bin <= {sh_bin[DATA_W-2:0], 1'b0};
      iter   <= ITER_W'(iter + 1'b1);
    end else if (state == ST_DONE) begin
      busy   <= 1'b0;
    end
  end

endmodule

// File: rtl/seg7_io_ctrl.sv
// Seven-segment display controller fed by the IO mux chip-select/write data.
// Latches the written word and scans 4 phases, each lighting one left-group
// and one right-group digit. Build option SEG7_DEC_EN shows the word in decimal.
//   clk, rst_n : clock, async active-low reset
//   seg_cs     : write strobe, seg_wdata : written word
//   seg_an     : digit enables, [7:4] left group, [3:0] right group
//   seg_a      : left-bus segments, seg_b : right-bus segments {dp,g..a}
//   busy       : decimal conversion in progress (0 in the hex build)
module seg7_io_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned        SCAN_DIV  = 100000,
  parameter logic [DATA_W-1:0]  RESET_VAL = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seg_cs,
  input  logic [DATA_W-1:0] seg_wdata,
  output logic [DIGITS-1:0] seg_an,
  output logic [7:0]        seg_a,
  output logic [7:0]        seg_b,
  output logic              busy
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0]   div_cnt;
  logic [PHASE_W-1:0] phase;
  logic [DATA_W-1:0]  disp_val;
  logic               dp_ovf;
  logic [3:0]         nib_a_c, nib_b_c;
  logic [3:0]         an_grp_c;
  logic               dp_c;

  // Scan divider and phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phase   <= '0;
    end else if (div_cnt == CNT_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      phase   <= PHASE_W'(phase + 1'b1);
    end else begin
      div_cnt <= CNT_W'(div_cnt + 1'b1);
    end
  end

`ifdef SEG7_DEC_EN
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done_c;

  seg7_bin2bcd u_bin2bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (seg_cs),
    .bin    (seg_wdata),
    .busy   (busy),
    .done_c (conv_done_c),
    .bcd    (conv_bcd)
  );

  // Display keeps the old digits until the converter completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val <= RESET_VAL;
      dp_ovf   <= 1'b0;
    end else if (conv_done_c) begin
      disp_val <= conv_bcd[DATA_W-1:0];
      dp_ovf   <= |conv_bcd[BCD_W-1:DATA_W];
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      disp_val <= RESET_VAL;
    else if (seg_cs) disp_val <= seg_wdata;
  end

  assign dp_ovf = 1'b0;
  assign busy   = 1'b0;
`endif

  // Phase p drives nibble 7-p on the left bus and 3-p on the right bus.
  always_comb begin
    an_grp_c = 4'(4'b1000 >> phase);
    nib_a_c  = 4'(disp_val >> {1'b1, ~phase, 2'b00});
    nib_b_c  = 4'(disp_val >> {1'b0, ~phase, 2'b00});
    dp_c     = dp_ovf && (phase == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_an <= '0;
      seg_a  <= '0;
      seg_b  <= '0;
    end else begin
      seg_an <= {an_grp_c, an_grp_c};
      seg_a  <= seg_enc(nib_a_c) | {dp_c, 7'b0};
      seg_b  <= seg_enc(nib_b_c);
    end
  end

endmodule

// File: tb/tb_seg7_io_ctrl.sv
// Self-checking bench for seg7_io_ctrl with SCAN_DIV=4, RESET_VAL=0.
module tb_seg7_io_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seg_cs = 1'b0;
  logic [31:0] seg_wdata = 32'h0;
  logic [7:0]  seg_an, seg_a, seg_b;
  logic        busy;

  seg7_io_ctrl #(.SCAN_DIV(4), .RESET_VAL(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .seg_cs(seg_cs), .seg_wdata(seg_wdata),
    .seg_an(seg_an), .seg_a(seg_a), .seg_b(seg_b), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] an; logic [7:0] a; logic [7:0] b; } obs_t;
  typedef struct packed { logic [31:0] wdata; logic [31:0] ea; logic [31:0] eb; } vec_t;

  obs_t        sb_q[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Expected per-phase outputs; byte 3 of ea/eb belongs to phase 0.
  task automatic push_phases(input logic [31:0] ea, input logic [31:0] eb);
    obs_t o;
    for (int p = 0; p < 4; p++) begin
      o.an = 8'(8'h88 >> p);
      o.a  = 8'(ea >> (24 - 8*p));
      o.b  = 8'(eb >> (24 - 8*p));
      sb_q.push_back(o);
    end
  endtask

  // Wait for the first negedge of a fresh phase-0 display window.
  task automatic wait_phase0();
    logic [7:0] prev;
    bit found;
    prev  = seg_an;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (seg_an == 8'h88 && prev != 8'h88) found = 1'b1;
      prev = seg_an;
    end
    if (!found) chk("phase0_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_phases(input string nm);
    obs_t e;
    wait_phase0();
    for (int p = 0; p < 4; p++) begin
      if (sb_q.size() == 0) begin
        chk({nm, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("%s_ph%0d", nm, p), 32'({seg_an, seg_a, seg_b}), 32'(e));
      end
      if (p < 3) repeat (4) @(negedge clk);
    end
  endtask

  task automatic write(input logic [31:0] d);
    @(negedge clk);
    seg_cs    = 1'b1;
    seg_wdata = d;
    @(negedge clk);
    seg_cs    = 1'b0;
    seg_wdata = $urandom;
  endtask

  // Count negedges with busy high; bounded.
  task automatic busy_len(output int unsigned n, output bit old_ok);
    n      = 0;
    old_ok = 1'b1;
    while (busy && n < 200) begin
      if (seg_a != 8'h3F || seg_b != 8'h3F) old_ok = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  vec_t        vecs[4];
  logic [7:0]  an_seq[4];
  int unsigned blen;
  bit          bok;

  initial begin
    vecs[0] = '{wdata: 32'h1234_ABCD, ea: 32'h065B_4F66, eb: 32'h777C_395E};
    vecs[1] = '{wdata: 32'hDEAD_BEEF, ea: 32'h5E79_775E, eb: 32'h7C79_7971};
    vecs[2] = '{wdata: 32'h7654_3210, ea: 32'h077D_6D66, eb: 32'h4F5B_063F};
    vecs[3] = '{wdata: 32'h0000_0008, ea: 32'h3F3F_3F3F, eb: 32'h3F3F_3F7F};
    an_seq  = '{8'h44, 8'h22, 8'h11, 8'h88};

    // Reset values and scan sequence.
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({seg_an, seg_a, seg_b, 7'b0, busy}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_pattern", 32'({seg_an, seg_a, seg_b}), 32'h88_3F_3F);
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("scan_an_%0d", k), 32'(seg_an), 32'(an_seq[k]));
    end

`ifdef SEG7_DEC_EN
    // Decimal conversion, old digits held while busy.
    write(32'd12345678);
    busy_len(blen, bok);
    chk("dec_busy_len", 32'(blen), 32'd33);
    chk("dec_old_digits", 32'(bok), 32'd1);
    push_phases(32'h065B_4F66, 32'h6D7D_077F);
    check_phases("dec_12345678");

    // Restart mid-conversion with an overflowing value.
    write(32'd4294967295);
    repeat (9) @(negedge clk);
    chk("dec_busy_mid", 32'(busy), 32'd1);
    write(32'd100000000);
    busy_len(blen, bok);
    chk("dec_restart_len", 32'(blen), 32'd33);
    push_phases(32'hBF3F_3F3F, 32'h3F3F_3F3F);
    check_phases("dec_overflow");
`else
    // Table-driven hex writes.
    for (int v = 0; v < 4; v++) begin
      write(vecs[v].wdata);
      push_phases(vecs[v].ea, vecs[v].eb);
      check_phases($sformatf("hex_vec%0d", v));
    end

    // seg_wdata changes without seg_cs must be ignored.
    repeat (5) begin
      @(negedge clk);
      seg_wdata = $urandom;
    end
    push_phases(32'h3F3F_3F3F, 32'h3F3F_3F7F);
    check_phases("hex_ignore");

    // Back-to-back writes: last one wins.
    write(32'h1234_ABCD);
    push_phases(32'h065B_4F66, 32'h777C_395E);
    check_phases("hex_pre_b2b");
    @(negedge clk);
    seg_cs    = 1'b1;
    seg_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    seg_wdata = 32'h0000_0008;
    @(negedge clk);
    seg_cs    = 1'b0;
    seg_wdata = 32'h5555_5555;
    push_phases(32'h3F3F_3F3F, 32'h3F3F_3F7F);
    check_phases("hex_b2b");
    chk("hex_busy_zero", 32'(busy), 32'd0);
`endif

    // Asynchronous reset in the middle of phase 2.
    write(32'hDEAD_BEEF);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (seg_an == 8'h22) seen = 1'b1;
      end
      chk("arst_reach_ph2", 32'(seen), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1 chk("arst_no_edge", 32'({seg_an, seg_a, seg_b, 7'b0, busy}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    push_phases(32'h3F3F_3F3F, 32'h3F3F_3F3F);
    check_phases("arst_zero");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
